// File: rtl/tcm_pkg.sv
// rtl/tcm_pkg.sv - shared types and defaults for the tightly-coupled memory responder
package tcm_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } tcm_state_e;

    localparam int          DEF_IMEM_AW = 10;
    localparam int          DEF_DMEM_AW = 12;
    localparam logic [31:0] DEF_NOP_INS = 32'h0000_0013;

endpackage

// File: rtl/tcm_ram.sv
// rtl/tcm_ram.sv - single-port RAM with per-bit write mask and registered, held read data
module tcm_ram #(
    parameter int AW    = 10,
    parameter int W     = 32,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wmask,
    input  logic [W-1:0]  i_wdat,
    output logic [W-1:0]  o_rdat
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdat;

    // Storage has no reset so contents survive a system reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= (r_mem[i_addr] & ~i_wmask) | (i_wdat & i_wmask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdat <= '0;
        end else if (i_re) begin
            r_rdat <= r_mem[i_addr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/tcm_responder.sv
// rtl/tcm_responder.sv - IMEM/DMEM responder with clear/load/run bring-up sequencing
module tcm_responder
    import tcm_pkg::*;
#(
    parameter int          IMEM_AW = DEF_IMEM_AW,
    parameter int          DMEM_AW = DEF_DMEM_AW,
    parameter logic [31:0] NOP_INS = DEF_NOP_INS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iFetchEn,
    input  logic [31:0]        iInsAddr,
    output logic [31:0]        oInsDat,
    input  logic               iMemEn,
    input  logic               iMemWrEn,
    input  logic [DMEM_AW-1:0] iMemAddr,
    input  logic [31:0]        iMemWrMask,
    input  logic [31:0]        iMemWrDat,
    output logic [31:0]        oMemDat,
    input  logic               iLdVld,
    output logic               oLdRdy,
    input  logic [IMEM_AW-1:0] iLdAddr,
    input  logic [31:0]        iLdDat,
    input  logic               iLdLast,
    output logic               oCoreHold
);

    tcm_state_e         r_state;
    tcm_state_e         w_next_state;
    logic [DMEM_AW-1:0] r_clr_cnt;
    logic               r_ins_oor;

    logic               w_clear;
    logic               w_load;
    logic               w_run;
    logic               w_ld_hs;
    logic               w_fetch;
    logic               w_ins_oor;
    logic [IMEM_AW-1:0] w_imem_addr;
    logic [31:0]        w_imem_q;
    logic               w_dmem_we;
    logic               w_dmem_re;
    logic [DMEM_AW-1:0] w_dmem_addr;
    logic [31:0]        w_dmem_mask;
    logic [31:0]        w_dmem_wdat;
    logic               w_unused_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        oLdRdy       = 1'b0;
        oCoreHold    = 1'b1;
        case (r_state)
            CLEAR: begin
                // Last index is being written this cycle; the counter wraps as we leave.
                if (&r_clr_cnt) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                oLdRdy = 1'b1;
                if (iLdVld && iLdLast) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                oCoreHold = 1'b0;
            end
            default: w_next_state = CLEAR;
        endcase
    end

    assign w_clear   = (r_state == CLEAR);
    assign w_load    = (r_state == LOAD);
    assign w_run     = (r_state == RUN);
    assign w_ld_hs   = w_load & iLdVld;
    assign w_fetch   = w_run & iFetchEn;
    assign w_ins_oor = |iInsAddr[31:IMEM_AW+2];

    assign w_unused_ok = &{1'b0, iInsAddr[1:0]};

    // Loader and fetch share the IMEM port; they are active in disjoint states.
    assign w_imem_addr = w_load ? iLdAddr : iInsAddr[IMEM_AW+1:2];

    tcm_ram #(.AW(IMEM_AW), .W(32)) u_imem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ld_hs),
        .i_re    (w_fetch & ~w_ins_oor),
        .i_addr  (w_imem_addr),
        .i_wmask ({32{1'b1}}),
        .i_wdat  (iLdDat),
        .o_rdat  (w_imem_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ins_oor <= 1'b0;
        end else if (w_fetch) begin
            r_ins_oor <= w_ins_oor;
        end
    end

    assign oInsDat = r_ins_oor ? NOP_INS : w_imem_q;

    assign w_dmem_we   = w_clear | (w_run & iMemEn & iMemWrEn);
    assign w_dmem_re   = w_run & iMemEn & ~iMemWrEn;
    assign w_dmem_addr = w_clear ? r_clr_cnt : iMemAddr;
    assign w_dmem_mask = w_clear ? {32{1'b1}} : iMemWrMask;
    assign w_dmem_wdat = w_clear ? 32'd0 : iMemWrDat;

    tcm_ram #(.AW(DMEM_AW), .W(32)) u_dmem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_dmem_we),
        .i_re    (w_dmem_re),
        .i_addr  (w_dmem_addr),
        .i_wmask (w_dmem_mask),
        .i_wdat  (w_dmem_wdat),
        .o_rdat  (oMemDat)
    );

endmodule

// File: tb/tb_tcm_responder.sv
// tb/tb_tcm_responder.sv - randomized bench for tcm_responder against a memory-array reference model
module tb_tcm_responder;
    import tcm_pkg::*;

    localparam int IAW = 10;
    localparam int DAW = 12;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic           clk = 1'b0;
    logic           rst;
    logic           iFetchEn;
    logic [31:0]    iInsAddr;
    logic [31:0]    oInsDat;
    logic           iMemEn;
    logic           iMemWrEn;
    logic [DAW-1:0] iMemAddr;
    logic [31:0]    iMemWrMask;
    logic [31:0]    iMemWrDat;
    logic [31:0]    oMemDat;
    logic           iLdVld;
    logic           oLdRdy;
    logic [IAW-1:0] iLdAddr;
    logic [31:0]    iLdDat;
    logic           iLdLast;
    logic           oCoreHold;

    always #5 clk = ~clk;

    tcm_responder #(.IMEM_AW(IAW), .DMEM_AW(DAW), .NOP_INS(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .iFetchEn   (iFetchEn),
        .iInsAddr   (iInsAddr),
        .oInsDat    (oInsDat),
        .iMemEn     (iMemEn),
        .iMemWrEn   (iMemWrEn),
        .iMemAddr   (iMemAddr),
        .iMemWrMask (iMemWrMask),
        .iMemWrDat  (iMemWrDat),
        .oMemDat    (oMemDat),
        .iLdVld     (iLdVld),
        .oLdRdy     (oLdRdy),
        .iLdAddr    (iLdAddr),
        .iLdDat     (iLdDat),
        .iLdLast    (iLdLast),
        .oCoreHold  (oCoreHold)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] imem_m [1 << IAW];
    bit          imem_v [1 << IAW];
    int          loaded_q [$];
    logic [31:0] dmem_m [1 << DAW];
    logic [31:0] exp_ins;
    logic [31:0] exp_mem;
    bit          m_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        iFetchEn   = 1'b0;
        iInsAddr   = '0;
        iMemEn     = 1'b0;
        iMemWrEn   = 1'b0;
        iMemAddr   = '0;
        iMemWrMask = '0;
        iMemWrDat  = '0;
        iLdVld     = 1'b0;
        iLdAddr    = '0;
        iLdDat     = '0;
        iLdLast    = 1'b0;
    endtask

    // One clock: apply the model to the inputs presented at this edge, then compare outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_run) begin
            if (iFetchEn) begin
                if (iInsAddr[31:IAW+2] != 0) exp_ins = NOP;
                else                          exp_ins = imem_m[iInsAddr[IAW+1:2]];
            end
            if (iMemEn && !iMemWrEn) exp_mem = dmem_m[iMemAddr];
            if (iMemEn && iMemWrEn)
                dmem_m[iMemAddr] = (dmem_m[iMemAddr] & ~iMemWrMask) | (iMemWrDat & iMemWrMask);
        end
        chk("oInsDat", oInsDat, exp_ins);
        chk("oMemDat", oMemDat, exp_mem);
        @(negedge clk);
    endtask

    task automatic reset_and_clear(input bit junk);
        int bad;
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oInsDat", oInsDat, 32'd0);
        chk("rst_oMemDat", oMemDat, 32'd0);
        chk("rst_oCoreHold", {31'd0, oCoreHold}, 32'd1);
        chk("rst_oLdRdy", {31'd0, oLdRdy}, 32'd0);
        exp_ins = '0;
        exp_mem = '0;
        m_run   = 1'b0;
        for (int i = 0; i < (1 << DAW); i++) dmem_m[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 1; k <= (1 << DAW); k++) begin
            if (junk) begin
                iLdVld     = 1'($urandom);
                iLdAddr    = IAW'($urandom);
                iLdDat     = $urandom;
                iLdLast    = 1'($urandom);
                iMemEn     = 1'b1;
                iMemWrEn   = 1'($urandom);
                iMemAddr   = DAW'($urandom);
                iMemWrMask = $urandom;
                iMemWrDat  = $urandom;
                iFetchEn   = 1'($urandom);
                iInsAddr   = $urandom;
            end
            @(posedge clk);
            #1;
            if (oLdRdy !== (k == (1 << DAW)) || oCoreHold !== 1'b1) bad++;
            if (oInsDat !== 32'd0 || oMemDat !== 32'd0) bad++;
            @(negedge clk);
        end
        idle_inputs();
        chk("clear_bad_cycles", 32'(bad), 32'd0);
        chk("ldrdy_after_clear", {31'd0, oLdRdy}, 32'd1);
        chk("hold_in_load", {31'd0, oCoreHold}, 32'd1);
    endtask

    task automatic ld_word(input int addr, input logic [31:0] dat, input bit last, input int gap);
        repeat (gap) tick();
        chk("ldrdy_before_hs", {31'd0, oLdRdy}, 32'd1);
        iLdVld  = 1'b1;
        iLdAddr = IAW'(addr);
        iLdDat  = dat;
        iLdLast = last;
        @(posedge clk);
        #1;
        imem_m[addr] = dat;
        if (!imem_v[addr]) loaded_q.push_back(addr);
        imem_v[addr] = 1'b1;
        if (last) m_run = 1'b1;
        chk(last ? "hold_after_last" : "hold_after_hs", {31'd0, oCoreHold}, last ? 32'd0 : 32'd1);
        @(negedge clk);
        iLdVld  = 1'b0;
        iLdLast = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        iFetchEn = 1'b1;
        iInsAddr = addr;
        tick();
        iFetchEn = 1'b0;
    endtask

    task automatic mem_load(input int addr);
        iMemEn   = 1'b1;
        iMemWrEn = 1'b0;
        iMemAddr = DAW'(addr);
        tick();
        iMemEn   = 1'b0;
    endtask

    task automatic mem_store(input int addr, input logic [31:0] dat, input logic [31:0] mask);
        iMemEn     = 1'b1;
        iMemWrEn   = 1'b1;
        iMemAddr   = DAW'(addr);
        iMemWrDat  = dat;
        iMemWrMask = mask;
        tick();
        iMemEn   = 1'b0;
        iMemWrEn = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w0, w1, w2, n0, n1, n3, ia;
        int          sel;
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < (1 << IAW); i++) imem_v[i] = 1'b0;
        exp_ins = '0;
        exp_mem = '0;
        m_run   = 1'b0;

        reset_and_clear(1'b1);

        // Core store and fetch while still in LOAD must be ignored.
        iMemEn     = 1'b1;
        iMemWrEn   = 1'b1;
        iMemAddr   = DAW'(9);
        iMemWrDat  = 32'hFFFF_FFFF;
        iMemWrMask = 32'hFFFF_FFFF;
        iFetchEn   = 1'b1;
        tick();
        idle_inputs();

        for (int i = 0; i < 8; i++) ld_word(16 + i, $urandom, 1'b0, int'($urandom_range(0, 2)));
        w0 = $urandom;
        w1 = $urandom;
        w2 = $urandom;
        ld_word(0, w0, 1'b0, 0);
        ld_word(1, w1, 1'b0, 1);
        ld_word(2, w2, 1'b1, 0);

        fetch(32'h0);
        chk("fetch_w0", oInsDat, w0);
        fetch(32'h4);
        chk("fetch_w1", oInsDat, w1);
        fetch(32'h8);
        chk("fetch_w2", oInsDat, w2);

        mem_store(5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        mem_store(5, 32'h0000_AA00, 32'h0000_FF00);
        mem_load(5);
        chk("merge_addr5", oMemDat, 32'hDEAD_AAEF);
        mem_load(7);
        chk("untouched_addr7", oMemDat, 32'd0);
        mem_load(9);
        chk("store_in_load_ignored", oMemDat, 32'd0);
        mem_load(4095);
        chk("top_addr_cleared", oMemDat, 32'd0);

        fetch(32'h0001_0000);
        chk("fetch_oor_nop", oInsDat, 32'h0000_0013);
        tick();
        chk("fetch_hold_nop", oInsDat, 32'h0000_0013);

        for (int n = 0; n < 400; n++) begin
            iFetchEn = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                ia = $urandom;
                if (ia[31:IAW+2] == 0) ia[20] = 1'b1;
            end else begin
                ia = (32'(loaded_q[$urandom_range(0, loaded_q.size() - 1)]) << 2) | 32'($urandom_range(0, 3));
            end
            iInsAddr = ia;
            sel = int'($urandom_range(0, 2));
            iMemEn     = (sel != 0);
            iMemWrEn   = (sel == 2);
            iMemAddr   = ($urandom_range(0, 3) == 0) ? DAW'($urandom) : DAW'($urandom_range(0, 15));
            iMemWrMask = $urandom;
            iMemWrDat  = $urandom;
            tick();
        end
        idle_inputs();

        // Reset while loading, then again, loading only a final word.
        reset_and_clear(1'b1);
        n0 = $urandom;
        n1 = $urandom;
        ld_word(0, n0, 1'b0, 0);
        ld_word(1, n1, 1'b0, 1);
        reset_and_clear(1'b0);
        n3 = $urandom;
        ld_word(3, n3, 1'b1, 2);

        fetch(32'h0);
        chk("refetch_0", oInsDat, n0);
        fetch(32'h4);
        chk("refetch_1", oInsDat, n1);
        fetch(32'hC);
        chk("fetch_3", oInsDat, n3);
        fetch(32'h8);
        chk("survived_w2", oInsDat, w2);
        fetch(32'h40);
        mem_load(5);
        chk("dmem_recleared", oMemDat, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
